// File: rtl/mem_dacc_if.sv
// mem_dacc_if: SRAM-like data bus between the memory-stage access controller
// and the data memory / cache.
//   master : controller side (drives the request, receives handshakes/data)
//   slave  : memory side
// Signals:
//   data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata : request
//   data_addr_ok : request accepted; data_data_ok : response/write completion
//   data_rdata   : read data, valid with data_data_ok
interface mem_dacc_if #(
    parameter int ADDR_W = 32
) ();
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_dacc.sv
// mem_dacc: memory-stage data-access controller. Turns one load/store per
// instruction into a req/addr_ok/data_ok bus transaction, stalls the pipeline
// while it is outstanding, buffers the returned load word and produces the
// lane code used by write-back extraction.
//
// Optional feature macro: DACC_ALIGN_CHK_EN
//   defined   : misaligned half/word accesses raise adel_o/ades_o and no
//               request is issued
//   undefined : no alignment exceptions; address low bits are masked to the
//               access size before lane/strobe generation
//
// Ports:
//   cpu_clk, cpu_rst_n         clock, async active-low reset
//   mem_valid_i/load_i/store_i MEM-stage instruction qualifiers
//   mem_size_i, mem_addr_i     access size (0 b, 1 h, 2/3 w) and address
//   mem_wdata_i                right-aligned store data
//   flush_i                    exception/ERET flush of the MEM stage
//   dbus                       data bus (master side)
//   stall_o                    freeze PC through EX/MEM
//   wb_dm_o, wb_dre_o          buffered load word and lane code (bit 3-k = lane k)
//   adel_o, ades_o, badvaddr_o alignment exceptions and faulting address
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; a new access may start this cycle
// REQ     | request presented, waiting for addr_ok; bus fields from copies
// WAIT    | request accepted, waiting for data_ok
// DONE    | one-cycle release after a completed (non-cancelled) access
module mem_dacc #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic              mem_valid_i,
    input  logic              mem_load_i,
    input  logic              mem_store_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    mem_dacc_if.master        dbus,
    output logic              stall_o,
    output logic [DATA_W-1:0] wb_dm_o,
    output logic [3:0]        wb_dre_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] badvaddr_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic [3:0]        dre_q, dre_d;
    logic [DATA_W-1:0] wb_dm_q, wb_dm_d;
    logic [3:0]        wb_dre_q, wb_dre_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

    logic              is_byte, is_half, is_word;
    logic              misal;
    logic [ADDR_W-1:0] addr_eff;
    logic [1:0]        off;
    logic [3:0]        dre_c, wstrb_c;
    logic [DATA_W-1:0] wdata_c;
    logic              start;
    logic              cancel_now;

    logic              bus_req, bus_wr, stall;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [DATA_W-1:0] bus_wdata;

    assign is_byte = (mem_size_i == 2'd0);
    assign is_half = (mem_size_i == 2'd1);
    assign is_word = mem_size_i[1];

`ifdef DACC_ALIGN_CHK_EN
    assign misal    = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    assign addr_eff = mem_addr_i;
`else
    assign misal = 1'b0;
    always_comb begin
        addr_eff = mem_addr_i;
        if (is_half) addr_eff[0] = 1'b0;
        if (is_word) addr_eff[1:0] = 2'b00;
    end
`endif

    assign off = addr_eff[1:0];

    // Lane code and strobes use opposite bit orders: dre bit (3-k) vs wstrb bit k.
    always_comb begin
        dre_c   = 4'b0000;
        wstrb_c = 4'b0000;
        wdata_c = mem_wdata_i;
        if (is_byte) begin
            dre_c   = 4'b1000 >> off;
            wstrb_c = 4'b0001 << off;
            wdata_c = {4{mem_wdata_i[7:0]}};
        end else if (is_half) begin
            dre_c   = off[1] ? 4'b0011 : 4'b1100;
            wstrb_c = off[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{mem_wdata_i[15:0]}};
        end else begin
            dre_c   = 4'b1111;
            wstrb_c = 4'b1111;
        end
        if (!mem_load_i) dre_c = 4'b0000;
        if (!mem_store_i) wstrb_c = 4'b0000;
    end

    assign start = (state_q == ST_IDLE) & mem_valid_i & (mem_load_i | mem_store_i)
                 & ~misal & ~flush_i;

    // A flush arriving in the same cycle as the response still cancels it.
    assign cancel_now = cancel_q | flush_i;

    always_comb begin
        state_d     = state_q;
        cancel_d    = cancel_q;
        dre_d       = dre_q;
        wb_dm_d     = wb_dm_q;
        wb_dre_d    = wb_dre_q;
        req_addr_d  = req_addr_q;
        req_wr_d    = req_wr_q;
        req_size_d  = req_size_q;
        req_wstrb_d = req_wstrb_q;
        req_wdata_d = req_wdata_q;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_size    = 2'b00;
        bus_addr    = addr_eff;
        bus_wstrb   = 4'b0000;
        bus_wdata   = '0;
        stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cancel_d = 1'b0;
                if (start) begin
                    bus_req     = 1'b1;
                    stall       = 1'b1;
                    bus_wr      = mem_store_i;
                    bus_size    = mem_size_i;
                    bus_wstrb   = wstrb_c;
                    bus_wdata   = wdata_c;
                    dre_d       = dre_c;
                    req_addr_d  = addr_eff;
                    req_wr_d    = mem_store_i;
                    req_size_d  = mem_size_i;
                    req_wstrb_d = wstrb_c;
                    req_wdata_d = wdata_c;
                    if (dbus.data_addr_ok) begin
                        if (dbus.data_data_ok) begin
                            wb_dm_d  = dbus.data_rdata;
                            wb_dre_d = dre_c;
                            state_d  = ST_DONE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                bus_req   = 1'b1;
                stall     = 1'b1;
                bus_wr    = req_wr_q;
                bus_size  = req_size_q;
                bus_addr  = req_addr_q;
                bus_wstrb = req_wstrb_q;
                bus_wdata = req_wdata_q;
                cancel_d  = cancel_now;
                if (dbus.data_addr_ok) begin
                    if (dbus.data_data_ok) begin
                        wb_dm_d  = dbus.data_rdata;
                        wb_dre_d = cancel_now ? 4'b0000 : dre_q;
                        state_d  = cancel_now ? ST_IDLE : ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall    = 1'b1;
                cancel_d = cancel_now;
                if (dbus.data_data_ok) begin
                    wb_dm_d  = dbus.data_rdata;
                    wb_dre_d = cancel_now ? 4'b0000 : dre_q;
                    state_d  = cancel_now ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= ST_IDLE;
            cancel_q    <= 1'b0;
            dre_q       <= 4'b0000;
            wb_dm_q     <= '0;
            wb_dre_q    <= 4'b0000;
            req_addr_q  <= '0;
            req_wr_q    <= 1'b0;
            req_size_q  <= 2'b00;
            req_wstrb_q <= 4'b0000;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cancel_q    <= cancel_d;
            dre_q       <= dre_d;
            wb_dm_q     <= wb_dm_d;
            wb_dre_q    <= wb_dre_d;
            req_addr_q  <= req_addr_d;
            req_wr_q    <= req_wr_d;
            req_size_q  <= req_size_d;
            req_wstrb_q <= req_wstrb_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    // The state is forced to IDLE during reset but the combinational start
    // path still sees live pipeline inputs; gate the outputs so the bus and
    // stall are quiet for the whole reset period.
    assign dbus.data_req   = bus_req & cpu_rst_n;
    assign dbus.data_wr    = bus_wr & cpu_rst_n;
    assign dbus.data_size  = bus_size & {2{cpu_rst_n}};
    assign dbus.data_addr  = bus_addr;
    assign dbus.data_wstrb = bus_wstrb & {4{cpu_rst_n}};
    assign dbus.data_wdata = bus_wdata & {DATA_W{cpu_rst_n}};
    assign stall_o         = stall & cpu_rst_n;

    assign adel_o     = cpu_rst_n & mem_valid_i & mem_load_i & misal;
    assign ades_o     = cpu_rst_n & mem_valid_i & mem_store_i & misal;
    assign badvaddr_o = mem_addr_i;

    assign wb_dm_o  = wb_dm_q;
    assign wb_dre_o = wb_dre_q;

endmodule

// File: tb/tb_mem_dacc.sv
// tb_mem_dacc: directed bench for mem_dacc. Inputs change 1 ns after the
// rising edge, outputs are checked before the next rising edge.
module tb_mem_dacc;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        mem_valid_i;
    logic        mem_load_i;
    logic        mem_store_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] wb_dm_o;
    logic [3:0]  wb_dre_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;

    int n_checks;
    int n_errors;

    mem_dacc_if #(.ADDR_W(32)) dbus ();

    mem_dacc #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .cpu_clk     (cpu_clk),
        .cpu_rst_n   (cpu_rst_n),
        .mem_valid_i (mem_valid_i),
        .mem_load_i  (mem_load_i),
        .mem_store_i (mem_store_i),
        .mem_size_i  (mem_size_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .flush_i     (flush_i),
        .dbus        (dbus.master),
        .stall_o     (stall_o),
        .wb_dm_o     (wb_dm_o),
        .wb_dre_o    (wb_dre_o),
        .adel_o      (adel_o),
        .ades_o      (ades_o),
        .badvaddr_o  (badvaddr_o)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic acc(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
        mem_valid_i = 1'b1;
        mem_load_i  = ld;
        mem_store_i = st;
        mem_size_i  = sz;
        mem_addr_i  = a;
        mem_wdata_i = wd;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        dbus.data_addr_ok = aok;
        dbus.data_data_ok = dok;
        dbus.data_rdata   = rd;
    endtask

    task automatic idle_in();
        mem_valid_i = 1'b0;
        mem_load_i  = 1'b0;
        mem_store_i = 1'b0;
        bus(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cpu_rst_n   = 1'b0;
        flush_i     = 1'b0;
        mem_size_i  = 2'd0;
        mem_addr_i  = 32'h0;
        mem_wdata_i = 32'h0;
        idle_in();

        // reset state
        #3;
        chk("rst_req", dbus.data_req, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_dm", wb_dm_o, 0);
        chk("rst_dre", wb_dre_o, 0);
        step();
        step();
        cpu_rst_n = 1'b1;
        step();

        // 1: lw 0x1000, addr_ok next cycle, data_ok two cycles after that
        acc(1, 0, 2'd2, 32'h1000, 32'h0);
        settle();
        chk("t1_c0_req", dbus.data_req, 1);
        chk("t1_c0_stall", stall_o, 1);
        chk("t1_c0_addr", dbus.data_addr, 32'h1000);
        chk("t1_c0_wr", dbus.data_wr, 0);
        step();
        bus(1, 0, 32'h0);
        settle();
        chk("t1_c1_req", dbus.data_req, 1);
        chk("t1_c1_stall", stall_o, 1);
        step();
        bus(0, 0, 32'h0);
        settle();
        chk("t1_c2_req", dbus.data_req, 0);
        chk("t1_c2_stall", stall_o, 1);
        step();
        bus(0, 1, 32'hDEADBEEF);
        settle();
        chk("t1_c3_stall", stall_o, 1);
        step();
        idle_in();
        settle();
        chk("t1_done_stall", stall_o, 0);
        chk("t1_done_req", dbus.data_req, 0);
        chk("t1_dm", wb_dm_o, 32'hDEADBEEF);
        chk("t1_dre", wb_dre_o, 32'hF);
        step();

        // 2: lb 0x1003 with addr_ok and data_ok together at start
        acc(1, 0, 2'd0, 32'h1003, 32'h0);
        bus(1, 1, 32'h80112233);
        settle();
        chk("t2_req", dbus.data_req, 1);
        chk("t2_stall", stall_o, 1);
        step();
        idle_in();
        settle();
        chk("t2_done_stall", stall_o, 0);
        chk("t2_dre", wb_dre_o, 32'h1);
        chk("t2_dm", wb_dm_o, 32'h80112233);
        step();

        // 5: lh 0x1002, flush in WAIT, data_ok three cycles later
        acc(1, 0, 2'd1, 32'h1002, 32'h0);
        bus(1, 0, 32'h0);
        settle();
        chk("t5_req", dbus.data_req, 1);
        step();
        idle_in();
        flush_i = 1'b1;
        settle();
        chk("t5_wait_stall", stall_o, 1);
        step();
        flush_i = 1'b0;
        settle();
        chk("t5_c2_stall", stall_o, 1);
        chk("t5_hold_dre", wb_dre_o, 32'h1);
        step();
        settle();
        chk("t5_c3_stall", stall_o, 1);
        step();
        bus(0, 1, 32'h12345678);
        settle();
        chk("t5_c4_stall", stall_o, 1);
        step();
        bus(0, 0, 32'h0);
        // back in IDLE (not DONE): a new access starts immediately
        acc(1, 0, 2'd2, 32'h3000, 32'h0);
        settle();
        chk("t5_dre_zero", wb_dre_o, 0);
        chk("t5_dm", wb_dm_o, 32'h12345678);
        chk("t5_restart_req", dbus.data_req, 1);
        bus(1, 1, 32'h55AA55AA);
        step();
        idle_in();
        settle();
        chk("t5_next_dre", wb_dre_o, 32'hF);
        chk("t5_next_dm", wb_dm_o, 32'h55AA55AA);
        step();

        // 3: sh 0x2002, request held from latched copies in REQ
        acc(0, 1, 2'd1, 32'h2002, 32'h0000ABCD);
        settle();
        chk("t3_wr", dbus.data_wr, 1);
        chk("t3_wstrb", dbus.data_wstrb, 32'hC);
        chk("t3_wdata", dbus.data_wdata, 32'hABCDABCD);
        step();
        mem_addr_i  = 32'h9999;
        mem_wdata_i = 32'hFFFF1111;
        bus(1, 0, 32'h0);
        settle();
        chk("t3_req_hold", dbus.data_req, 1);
        chk("t3_addr_hold", dbus.data_addr, 32'h2002);
        chk("t3_wdata_hold", dbus.data_wdata, 32'hABCDABCD);
        chk("t3_wstrb_hold", dbus.data_wstrb, 32'hC);
        chk("t3_wr_hold", dbus.data_wr, 1);
        step();
        bus(0, 1, 32'h0);
        step();
        idle_in();
        settle();
        chk("t3_done_stall", stall_o, 0);
        chk("t3_dre", wb_dre_o, 0);
        step();

        // sb 0x2001: flush in IDLE suppresses start, then byte store lanes
        acc(0, 1, 2'd0, 32'h2001, 32'h000000EF);
        flush_i = 1'b1;
        settle();
        chk("sb_flush_req", dbus.data_req, 0);
        chk("sb_flush_stall", stall_o, 0);
        flush_i = 1'b0;
        #1;
        chk("sb_req", dbus.data_req, 1);
        chk("sb_wstrb", dbus.data_wstrb, 32'h2);
        chk("sb_wdata", dbus.data_wdata, 32'hEFEFEFEF);
        bus(1, 1, 32'h0);
        step();
        idle_in();
        settle();
        chk("sb_done_stall", stall_o, 0);
        step();

        // 4: lw 0x1002
        acc(1, 0, 2'd2, 32'h1002, 32'h0);
        settle();
        chk("t4_badva", badvaddr_o, 32'h1002);
`ifdef DACC_ALIGN_CHK_EN
        chk("t4_adel", adel_o, 1);
        chk("t4_req", dbus.data_req, 0);
        chk("t4_stall", stall_o, 0);
        step();
        settle();
        chk("t4_req_c1", dbus.data_req, 0);
        chk("t4_stall_c1", stall_o, 0);
        idle_in();
        step();
`else
        chk("t4_adel", adel_o, 0);
        chk("t4_req", dbus.data_req, 1);
        chk("t4_addr", dbus.data_addr, 32'h1000);
        bus(1, 1, 32'h0BADF00D);
        step();
        idle_in();
        settle();
        chk("t4_dre", wb_dre_o, 32'hF);
        chk("t4_dm", wb_dm_o, 32'h0BADF00D);
        step();
`endif

        // 6: reset during REQ, then a normal lw
        acc(1, 0, 2'd2, 32'h4000, 32'h0);
        step();
        settle();
        chk("t6_req_before", dbus.data_req, 1);
        cpu_rst_n = 1'b0;
        #1;
        chk("t6_rst_req", dbus.data_req, 0);
        chk("t6_rst_stall", stall_o, 0);
        chk("t6_rst_dm", wb_dm_o, 0);
        chk("t6_rst_dre", wb_dre_o, 0);
        step();
        cpu_rst_n = 1'b1;
        step();
        settle();
        chk("t6_new_req", dbus.data_req, 1);
        chk("t6_new_addr", dbus.data_addr, 32'h4000);
        step();
        bus(1, 0, 32'h0);
        settle();
        chk("t6_reqst_req", dbus.data_req, 1);
        step();
        bus(0, 1, 32'hCAFEF00D);
        settle();
        chk("t6_wait_stall", stall_o, 1);
        step();
        idle_in();
        settle();
        chk("t6_done_stall", stall_o, 0);
        chk("t6_dm", wb_dm_o, 32'hCAFEF00D);
        chk("t6_dre", wb_dre_o, 32'hF);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
